// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one single-port RAM between two requesters. Arbitration is
// round-robin, and only one RAM access is in flight at a time.
//
// Handshake: a command transfers in the cycle where reqN_valid && reqN_ready
// are both high. Once a requester raises valid, it must hold valid and the
// command fields stable until ready. reqN_ready is combinational. It goes high
// only in IDLE, and only for the arbitration winner.
// A read result is returned as a one-cycle rspN_valid pulse. rspN_rdata then
// holds that value until the next read for the same requester.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   reqN_valid/ready      command handshake for requester N (N = 0, 1)
//   reqN_write            1 = write, 0 = read
//   reqN_addr/wdata       command address and write data
//   rspN_valid/rdata      read-response pulse and read data
//   ram_*                 single-port RAM interface (address, data_in,
//                         write, select, data_out)
//   o_dbg_state           current FSM state (0 IDLE, 1 ACCESS, 2 READ_WAIT)
module ram_arbiter #(
    parameter int AW     = 10,
    parameter int DW     = 10,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_write,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_write,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_write,
    output logic          ram_select,
    input  logic [DW-1:0] ram_data_out,
    output logic [1:0]    o_dbg_state
);

    localparam int CW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        READ_WAIT = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_last_grant;
    logic          r_id;
    logic          r_write;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [CW-1:0] r_cnt;
    logic          r_rsp0_valid;
    logic          r_rsp1_valid;
    logic [DW-1:0] r_rsp0_rdata;
    logic [DW-1:0] r_rsp1_rdata;

    logic          w_winner;
    logic          w_grant_ok;
    logic          w_ready0;
    logic          w_ready1;
    logic          w_handshake;
    logic          w_last_wait;

    // When both requesters are valid, the one that was not granted last wins.
    // When only one is valid, that one wins, and the tie-break is not used.
    assign w_winner    = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    // reset gates ready so that no requester is acknowledged while the
    // arbiter is held in reset.
    assign w_grant_ok  = (r_state == IDLE) && (req0_valid || req1_valid) && !reset;
    assign w_handshake = w_ready0 || w_ready1;
    assign w_last_wait = (r_state == READ_WAIT) && (r_cnt == CW'(1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (w_handshake) w_next_state = ACCESS;
            ACCESS:    w_next_state = r_write ? IDLE : READ_WAIT;
            READ_WAIT: if (w_last_wait) w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_ready0   = w_grant_ok && !w_winner;
        w_ready1   = w_grant_ok && w_winner;
        ram_select = (r_state == ACCESS);
        ram_write  = (r_state == ACCESS) && r_write;
    end

    // Command latch, read-wait counter and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
        end else begin
            if (w_handshake) begin
                r_id         <= w_winner;
                r_last_grant <= w_winner;
                r_write      <= w_winner ? req1_write : req0_write;
                r_addr       <= w_winner ? req1_addr  : req0_addr;
                r_wdata      <= w_winner ? req1_wdata : req0_wdata;
            end

            if (r_state == ACCESS && !r_write) begin
                r_cnt <= CW'(RD_LAT);
            end else if (r_state == READ_WAIT) begin
                r_cnt <= r_cnt - CW'(1);
            end

            // The RAM data is sampled in the last wait cycle. The response
            // pulse appears in the following cycle.
            r_rsp0_valid <= w_last_wait && !r_id;
            r_rsp1_valid <= w_last_wait && r_id;
            if (w_last_wait && !r_id) r_rsp0_rdata <= ram_data_out;
            if (w_last_wait && r_id)  r_rsp1_rdata <= ram_data_out;
        end
    end

    assign req0_ready  = w_ready0;
    assign req1_ready  = w_ready1;
    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp0_rdata  = r_rsp0_rdata;
    assign rsp1_rdata  = r_rsp1_rdata;
    // The latched command is kept until the next handshake. As a result,
    // the RAM address and data hold their last values outside ACCESS.
    assign ram_address = r_addr;
    assign ram_data_in = r_wdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    int         errors = 0;
    int         checks = 0;

    // Instance a: RD_LAT = 1, backed by a behavioural RAM
    logic       req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
    logic [9:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [9:0] rsp0_rdata, rsp1_rdata, ram_address, ram_data_in, ram_data_out;
    logic       ram_write, ram_select;
    logic [1:0] dbg_state;

    // Instance b: RD_LAT = 3, with RAM data driven directly by the bench
    logic       b_req0_valid = 0, b_req0_write = 0, b_req1_valid = 0, b_req1_write = 0;
    logic [9:0] b_req0_addr = 0, b_req0_wdata = 0, b_req1_addr = 0, b_req1_wdata = 0;
    logic       b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid;
    logic [9:0] b_rsp0_rdata, b_rsp1_rdata, b_ram_address, b_ram_data_in;
    logic [9:0] b_ram_data_out = 0;
    logic       b_ram_write, b_ram_select;
    logic [1:0] b_dbg_state;

    logic [9:0] mem [0:1023];
    logic [9:0] ram_q = 0;

    always #5 clk = ~clk;

    // Synchronous RAM model: read data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (ram_select) begin
            if (ram_write) mem[ram_address] <= ram_data_in;
            else           ram_q <= mem[ram_address];
        end
    end
    assign ram_data_out = ram_q;

    ram_arbiter #(.AW(10), .DW(10), .RD_LAT(1)) u_dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_write(ram_write), .ram_select(ram_select),
        .ram_data_out(ram_data_out), .o_dbg_state(dbg_state)
    );

    ram_arbiter #(.AW(10), .DW(10), .RD_LAT(3)) u_dut_b (
        .clk(clk), .reset(reset),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_write(b_req0_write),
        .req0_addr(b_req0_addr), .req0_wdata(b_req0_wdata),
        .rsp0_valid(b_rsp0_valid), .rsp0_rdata(b_rsp0_rdata),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_write(b_req1_write),
        .req1_addr(b_req1_addr), .req1_wdata(b_req1_wdata),
        .rsp1_valid(b_rsp1_valid), .rsp1_rdata(b_rsp1_rdata),
        .ram_address(b_ram_address), .ram_data_in(b_ram_data_in),
        .ram_write(b_ram_write), .ram_select(b_ram_select),
        .ram_data_out(b_ram_data_out), .o_dbg_state(b_dbg_state)
    );

    // Inputs change 1 time unit after the rising edge; checks run on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1;  // ready must stay low while reset is held
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, ram_select, ram_write} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes got=%b exp=000000",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, ram_select, ram_write});
        end
        checks++;
        if ({ram_address, ram_data_in, rsp0_rdata, rsp1_rdata, dbg_state} !== 42'b0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=0",
                     {ram_address, ram_data_in, rsp0_rdata, rsp1_rdata, dbg_state});
        end
        tick();
        req0_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_write();
        tick();
        req0_valid = 1; req0_write = 1; req0_addr = 10'd5; req0_wdata = 10'h2A5;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL write_ready got=%b exp=10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 0;
        @(negedge clk);
        checks++;
        if ({ram_select, ram_write, ram_address, ram_data_in} !== {2'b11, 10'd5, 10'h2A5}) begin
            errors++;
            $display("FAIL write_strobe got sel=%b wr=%b a=%h d=%h exp 1 1 005 2a5",
                     ram_select, ram_write, ram_address, ram_data_in);
        end
        tick();
        @(negedge clk);
        checks++;
        if (ram_select !== 1'b0 || dbg_state !== 2'd0) begin
            errors++; $display("FAIL write_idle got sel=%b st=%0d exp 0 0", ram_select, dbg_state);
        end
    endtask

    task automatic test_read();
        tick();
        req1_valid = 1; req1_write = 0; req1_addr = 10'd5;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++; $display("FAIL read_ready got=%b exp=01", {req0_ready, req1_ready});
        end
        tick();
        req1_valid = 0;
        @(negedge clk);
        checks++;
        if ({ram_select, ram_write, ram_address} !== {2'b10, 10'd5}) begin
            errors++;
            $display("FAIL read_strobe got sel=%b wr=%b a=%h exp 1 0 005", ram_select, ram_write, ram_address);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rsp1_valid !== 1'b0) begin
            errors++; $display("FAIL read_early got=%b exp=0", rsp1_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({rsp1_valid, rsp0_valid, rsp1_rdata} !== {2'b10, 10'h2A5}) begin
            errors++;
            $display("FAIL read_rsp got v1=%b v0=%b d=%h exp 1 0 2a5", rsp1_valid, rsp0_valid, rsp1_rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rsp1_valid !== 1'b0 || rsp1_rdata !== 10'h2A5) begin
            errors++; $display("FAIL read_hold got v=%b d=%h exp 0 2a5", rsp1_valid, rsp1_rdata);
        end
    endtask

    task automatic test_alternate();
        int         n0 = 0;
        int         n1 = 0;
        logic       g0 = 0;
        logic       g1 = 0;
        logic [9:0] exp_addr = 0;
        int         exp_g;
        tick();
        req0_valid = 1; req0_write = 1; req0_addr = 10'h100; req0_wdata = 10'h100;
        req1_valid = 1; req1_write = 1; req1_addr = 10'h200; req1_wdata = 10'h200;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                tick();
                if (g0) begin n0++; req0_addr = 10'h100 + 10'(n0); req0_wdata = req0_addr; end
                if (g1) begin n1++; req1_addr = 10'h200 + 10'(n1); req1_wdata = req1_addr; end
            end
            @(negedge clk);
            g0 = req0_ready;
            g1 = req1_ready;
            if (c % 2 == 0) begin
                exp_g = (c / 2) % 2;
                exp_addr = (exp_g == 0) ? req0_addr : req1_addr;
                checks++;
                if ({req0_ready, req1_ready} !== ((exp_g == 0) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL alt_grant c=%0d got=%b exp_winner=%0d", c, {req0_ready, req1_ready}, exp_g);
                end
            end else begin
                checks++;
                if ({req0_ready, req1_ready, ram_select, ram_write} !== 4'b0011 || ram_address !== exp_addr) begin
                    errors++;
                    $display("FAIL alt_strobe c=%0d got rdy=%b sel=%b a=%h exp 00 1 %h",
                             c, {req0_ready, req1_ready}, ram_select, ram_address, exp_addr);
                end
            end
        end
        tick();
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic do_write0(input logic [9:0] a, input logic [9:0] d);
        int n = 0;
        tick();
        req0_valid = 1; req0_write = 1; req0_addr = a; req0_wdata = d;
        @(negedge clk);
        while (!req0_ready && n < 20) begin @(negedge clk); n++; end
        if (!req0_ready) begin
            errors++; checks++;
            $display("FAIL fill_write_timeout addr=%h ready=%b exp=1", a, req0_ready);
        end
        tick();
        req0_valid = 0;
    endtask

    task automatic do_read1(input logic [9:0] a);
        int n = 0;
        tick();
        req1_valid = 1; req1_write = 0; req1_addr = a;
        @(negedge clk);
        while (!req1_ready && n < 20) begin @(negedge clk); n++; end
        tick();
        req1_valid = 0;
        n = 0;
        @(negedge clk);
        while (!rsp1_valid && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_rdata !== a) begin
            errors++; $display("FAIL fill_read addr=%h got v=%b d=%h exp 1 %h", a, rsp1_valid, rsp1_rdata, a);
        end
    endtask

    task automatic test_fill();
        for (int a = 0; a < 1024; a++) do_write0(10'(a), 10'(a));
        for (int a = 0; a < 1024; a++) do_read1(10'(a));
    endtask

    task automatic test_reset_mid_read();
        int bad = 0;
        tick();
        req0_valid = 1; req0_write = 0; req0_addr = 10'd7;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL rst_read_ready got=%b exp=1", req0_ready);
        end
        tick();
        req0_valid = 0;
        tick();
        checks++;
        if (dbg_state !== 2'd2) begin
            errors++; $display("FAIL rst_in_wait got state=%0d exp=2", dbg_state);
        end
        reset = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, ram_select, ram_write,
             ram_address, ram_data_in, rsp0_rdata, rsp1_rdata, dbg_state} !== 48'b0) begin
            errors++;
            $display("FAIL rst_async got rsp1_rdata=%h addr=%h state=%0d exp all 0",
                     rsp1_rdata, ram_address, dbg_state);
        end
        tick();
        reset = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp0_valid !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rst_no_rsp got %0d pulses exp 0", bad);
        end
        req0_valid = 1; req0_write = 0; req0_addr = 10'd3;
        req1_valid = 1; req1_write = 0; req1_addr = 10'd4;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL rst_priority got=%b exp=10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 0; req1_valid = 0;
        repeat (4) tick();
    endtask

    task automatic test_rdlat3();
        tick();
        b_req0_valid = 1; b_req0_write = 0; b_req0_addr = 10'd9; b_ram_data_out = 10'h100;
        @(negedge clk);
        checks++;
        if (b_req0_ready !== 1'b1) begin
            errors++; $display("FAIL lat3_accept got=%b exp=1", b_req0_ready);
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            b_ram_data_out = 10'h100 + 10'(c);
            @(negedge clk);
            checks++;
            if ({b_req0_ready, b_rsp0_valid, b_ram_select} !== {2'b00, (c == 1)}) begin
                errors++;
                $display("FAIL lat3_wait c=%0d got rdy=%b v=%b sel=%b exp 0 0 %0d",
                         c, b_req0_ready, b_rsp0_valid, b_ram_select, (c == 1));
            end
        end
        tick();
        b_ram_data_out = 10'h105;
        @(negedge clk);
        checks++;
        if ({b_rsp0_valid, b_req0_ready, b_rsp0_rdata} !== {2'b11, 10'h104}) begin
            errors++;
            $display("FAIL lat3_rsp got v=%b rdy=%b d=%h exp 1 1 104", b_rsp0_valid, b_req0_ready, b_rsp0_rdata);
        end
        tick();
        b_req0_valid = 0;
        repeat (6) tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_write();
        test_read();
        test_alternate();
        test_fill();
        test_reset_mid_read();
        test_rdlat3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port RAM (1024 x 10, ports address/data_in/data_out/write/select) between two requesters.
- Round-robin arbitration, valid/ready command handshake, one-cycle read-response pulse.
- Sits between the RAM and two client blocks, e.g. a loader and a consumer.
- One access in flight at a time; drives the RAM select/write strobe for exactly one cycle per access.

Parameters:
- AW, 10, RAM address width
- DW, 10, RAM data width
- RD_LAT, 1, cycles from the RAM strobe cycle until ram_data_out is valid; must be >= 1

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 command accepted this cycle
- req0_write  in  1  1 = write, 0 = read
- req0_addr  in  AW  requester 0 address
- req0_wdata  in  DW  requester 0 write data
- rsp0_valid  out  1  one-cycle pulse: rsp0_rdata valid
- rsp0_rdata  out  DW  read data for requester 0
- req1_*, rsp1_*  same set of signals as requester 0, for requester 1
- ram_address  out  AW  to RAM address
- ram_data_in  out  DW  to RAM data_in
- ram_write  out  1  to RAM write
- ram_select  out  1  to RAM select
- ram_data_out  in  DW  from RAM data_out

Behaviour:
- Reset (async, any time): state=IDLE, last_grant=1 (so requester 0 wins first).
  - Outputs cleared: all ready/rsp_valid/ram_select/ram_write = 0; ram_address, ram_data_in, rsp*_rdata = 0.
  - Any in-flight access is aborted; no response is issued for it.
- States:
  - IDLE: if any reqN_valid, grant the winner.
  - ACCESS: one cycle; RAM strobed.
  - READ_WAIT: RD_LAT cycles.
- Arbitration (IDLE only):
  - Exactly one valid: that requester wins.
  - Both valid: winner = requester != last_grant.
  - reqN_ready = 1 combinationally, only for the winner, only in IDLE.
- On handshake (valid & ready):
  - Latch write/addr/wdata and the winner id.
  - Set last_grant = winner; go to ACCESS.
- ACCESS:
  - ram_select=1, ram_write=latched write, ram_address=latched addr, ram_data_in=latched wdata.
  - Write: next state IDLE.
  - Read: load the wait counter with RD_LAT; next state READ_WAIT.
- Outside ACCESS: ram_select=0, ram_write=0. ram_address/ram_data_in hold their last values.
- READ_WAIT:
  - Counter decrements each cycle.
  - In the last cycle, capture ram_data_out into the winner's rspN_rdata; next state IDLE.
  - rspN_valid = 1 for exactly the following cycle (registered).
- rspN_rdata holds its value until the next read for that requester.
- Timing (handshake in cycle T):
  - RAM strobe in T+1.
  - Write: next accept possible in T+2.
  - Read: rsp_valid in T+2+RD_LAT; a new handshake may occur in that same cycle.
- Throughput: writes one per 2 cycles; reads one per 2+RD_LAT cycles.
- Requesters hold valid and command fields until ready. If valid drops before ready, no access occurs.
- The other requester's ready stays 0 whenever it is not granted. Never grant both in one cycle.
- last_grant changes only on a handshake; idle cycles do not rotate priority.
- Address wrap: none. The arbiter passes addresses through unmodified; 1023 is a legal address.

Test Plan:
- Reset, then req0 write addr=5 data=0x2A5 → req0_ready in cycle 0; ram_select=ram_write=1 with address 5 in cycle 1; idle from cycle 2 onward.
- req1 read addr=5 after the write above, RD_LAT=1 → ram_select=1, ram_write=0 in cycle 1; rsp1_valid=1 with rsp1_rdata=0x2A5 in cycle 3 only; rsp0_valid stays 0.
- Both valid continuously, writing addr=k / data=k → grants alternate 0,1,0,1 starting with 0; one strobe every 2 cycles; never both readies high together.
- Fill all 1024 addresses via req0 (data=addr), then read them all back via req1 → every rsp1_rdata equals its address, including addresses 0 and 1023.
- Assert reset during READ_WAIT of a req0 read → all outputs go to 0 immediately; no rsp0_valid after reset releases; the next request with both valid is granted to req0.
- Run with RD_LAT=3: read handshake in T → rsp_valid in T+5; no new ready is asserted in cycles T+1 to T+4.
